// File: rtl/communication_send_arbiter_pkg.sv
// Shared types and constants for the send arbiter.
// State encoding, byte width, default frame length.
package comm_pkg;

  localparam int BYTE_W = 8;
  localparam int FRAME_CYCLES_DEF = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_e;

  function automatic int cnt_w(
    input int a,
    input int b
  );
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/communication_send_arbiter_if.sv
// Requester/sender bundle of the send arbiter.
// master = byte producers side, slave = arbiter.
interface communication_send_arbiter_if
  import comm_pkg::*;
#(
  parameter int NREQ = 4
) ();

  localparam int GW =
    (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                     enable;
  logic [NREQ-1:0]          req;
  logic [NREQ*BYTE_W-1:0]   req_data;
  logic [NREQ-1:0]          req_ack;
  logic [NREQ-1:0]          req_done;
  logic [BYTE_W-1:0]        tx_data;
  logic                     tx_load;
  logic                     tx_en;
  logic                     busy;
  logic [GW-1:0]            cur_grant;

  modport master (
    output enable, req, req_data,
    input  req_ack, req_done,
    input  tx_data, tx_load, tx_en,
    input  busy, cur_grant
  );

  modport slave (
    input  enable, req, req_data,
    output req_ack, req_done,
    output tx_data, tx_load, tx_en,
    output busy, cur_grant
  );

endinterface

// File: rtl/communication_send_arbiter_rr_pick.sv
// Combinational winner picker for the send arbiter.
// FIXED_PRIO_EN selects lowest-index priority instead of round-robin.
module comm_rr_pick
  import comm_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [GW-1:0]   i_last,
  output logic [GW-1:0]   o_win,
  output logic            o_valid
);

`ifdef FIXED_PRIO_EN

  logic w_unused;
  assign w_unused = ^i_last;

  // lowest set index wins; scan downward so index 0 overrides
  always_comb begin
    o_win   = '0;
    o_valid = |i_req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) o_win = GW'(i);
    end
  end

`else

  // first set bit after the last winner, wrapping modulo NREQ
  always_comb begin
    int idx;
    idx     = 0;
    o_win   = '0;
    o_valid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(i_last) + k) % NREQ;
      if (!o_valid && i_req[idx]) begin
        o_valid = 1'b1;
        o_win   = GW'(idx);
      end
    end
  end

`endif

endmodule

// File: rtl/communication_send_arbiter.sv
// Shares one serial byte sender among NREQ sources, one frame each.
// Build option FIXED_PRIO_EN: fixed lowest-index priority picker.
module communication_send_arbiter
  import comm_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int GAP_CYCLES = 2
) (
  input logic clk1,
  input logic rst,
  communication_send_arbiter_if.slave bus
);

  localparam int GW =
    (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW =
    cnt_w(FRAME_CYCLES, GAP_CYCLES);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [CW-1:0] FRAME_LD =
    CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD =
    CW'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  state_e r_state;
  state_e w_next;

  logic [CW-1:0]          r_cnt;
  logic [NREQ-1:0]        r_req;
  logic [NREQ*BYTE_W-1:0] r_data;
  logic [GW-1:0]          r_last;
  logic [GW-1:0]          r_grant;
  logic [BYTE_W-1:0]      r_tx_data;
  logic                   r_tx_en;

  logic [GW-1:0]          w_win;
  logic                   w_valid;
  logic                   w_go;
  logic                   w_zero;
  logic [NREQ-1:0]        w_onehot;

  comm_rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .i_req   (r_req),
    .i_last  (r_last),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  assign w_go = (r_state == IDLE) &
                bus.enable & w_valid;
  assign w_zero = (r_cnt == '0);

  // register request levels and bytes for the picker
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_req  <= '0;
      r_data <= '0;
    end else begin
      r_req  <= bus.req;
      r_data <= bus.req_data;
    end
  end

  // state register
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // next state: grant, frame timing, gap, abort
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_go) w_next = LOAD;
      LOAD: w_next = bus.enable ? SEND : IDLE;
      SEND: begin
        if (!bus.enable)
          w_next = IDLE;
        else if (w_zero)
          w_next = HAS_GAP ? GAP : IDLE;
      end
      GAP: begin
        if (!bus.enable || w_zero)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // frame / gap down-counter, cleared on abort
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: r_cnt <= '0;
        LOAD: r_cnt <= bus.enable ? FRAME_LD : '0;
        SEND: begin
          if (!bus.enable)
            r_cnt <= '0;
          else if (w_zero)
            r_cnt <= HAS_GAP ? GAP_LD : '0;
          else
            r_cnt <= r_cnt - CW'(1);
        end
        GAP: begin
          if (!bus.enable || w_zero)
            r_cnt <= '0;
          else
            r_cnt <= r_cnt - CW'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // latch winner byte/index, advance pointer, track enable
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_tx_data <= '0;
      r_grant   <= '0;
      r_last    <= GW'(NREQ - 1);
      r_tx_en   <= 1'b0;
    end else begin
      r_tx_en <= bus.enable;
      if (w_go) begin
        r_tx_data <=
          r_data[int'(w_win)*BYTE_W +: BYTE_W];
        r_grant <= w_win;
      end
      if (r_state == LOAD)
        r_last <= r_grant;
    end
  end

  // outputs decoded from state and counter
  always_comb begin
    w_onehot = '0;
    w_onehot[r_grant] = 1'b1;
    bus.tx_load   = (r_state == LOAD);
    bus.req_ack   = '0;
    bus.req_done  = '0;
    bus.busy      = (r_state != IDLE);
    bus.tx_data   = r_tx_data;
    bus.tx_en     = r_tx_en;
    bus.cur_grant = r_grant;
    if (r_state == LOAD)
      bus.req_ack = w_onehot;
    if ((r_state == SEND) && w_zero && bus.enable)
      bus.req_done = w_onehot;
  end

endmodule

// File: tb/tb_communication_send_arbiter.sv
// Directed self-checking bench for communication_send_arbiter.
// dut0: default timing, dut1: GAP_CYCLES=0.
module tb_communication_send_arbiter;

  import comm_pkg::*;

  logic clk1 = 1'b0;
  logic rst  = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk1 = ~clk1;

  communication_send_arbiter_if #(.NREQ(4)) bus0 ();
  communication_send_arbiter_if #(.NREQ(4)) bus1 ();

  communication_send_arbiter #(
    .NREQ         (4),
    .FRAME_CYCLES (13),
    .GAP_CYCLES   (2)
  ) dut0 (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus0.slave)
  );

  communication_send_arbiter #(
    .NREQ         (4),
    .FRAME_CYCLES (13),
    .GAP_CYCLES   (0)
  ) dut1 (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus1.slave)
  );

  task automatic step();
    @(negedge clk1);
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_load0(
    input  int max,
    output int cyc,
    output int acks
  );
    step();
    cyc  = 1;
    acks = $countones(bus0.req_ack);
    while (!bus0.tx_load && cyc < max) begin
      step();
      cyc++;
      acks += $countones(bus0.req_ack);
    end
    chk("load0_seen", 32'(bus0.tx_load), 1);
  endtask

  task automatic wait_load1(
    input  int max,
    output int cyc
  );
    step();
    cyc = 1;
    while (!bus1.tx_load && cyc < max) begin
      step();
      cyc++;
    end
    chk("load1_seen", 32'(bus1.tx_load), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int acks;
    int dn;
    int exp_g[5];
    int exp_ab1;
    int exp_ab2;

`ifdef FIXED_PRIO_EN
    exp_g   = '{0, 0, 0, 0, 0};
    exp_ab1 = 0;
    exp_ab2 = 0;
`else
    exp_g   = '{0, 1, 2, 3, 0};
    exp_ab1 = 1;
    exp_ab2 = 2;
`endif

    bus0.enable   = 1'b0;
    bus0.req      = '0;
    bus0.req_data = '0;
    bus1.enable   = 1'b0;
    bus1.req      = '0;
    bus1.req_data = '0;

    // reset values
    rst = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(bus0.busy), 0);
    chk("rst_tx_en", 32'(bus0.tx_en), 0);
    chk("rst_load", 32'(bus0.tx_load), 0);
    chk("rst_data", 32'(bus0.tx_data), 0);
    chk("rst_grant", 32'(bus0.cur_grant), 0);
    chk("rst_ack", 32'(bus0.req_ack), 0);
    chk("rst_done", 32'(bus0.req_done), 0);
    rst = 1'b1;
    step();

    // single byte A5 from requester 0
    bus0.enable   = 1'b1;
    bus0.req      = 4'b0001;
    bus0.req_data = 32'h0000_00A5;
    step();
    chk("lat_c1_load", 32'(bus0.tx_load), 0);
    step();
    chk("lat_c2_load", 32'(bus0.tx_load), 1);
    chk("c2_data", 32'(bus0.tx_data), 32'hA5);
    chk("c2_ack", 32'(bus0.req_ack), 1);
    chk("c2_grant", 32'(bus0.cur_grant), 0);
    chk("c2_busy", 32'(bus0.busy), 1);
    chk("c2_tx_en", 32'(bus0.tx_en), 1);
    bus0.req = 4'b0000;
    repeat (12) step();
    chk("send12_done", 32'(bus0.req_done), 0);
    chk("send_hold", 32'(bus0.tx_data), 32'hA5);
    step();
    chk("send13_done", 32'(bus0.req_done), 1);
    step();
    chk("gap1_busy", 32'(bus0.busy), 1);
    step();
    chk("gap2_busy", 32'(bus0.busy), 1);
    step();
    chk("idle_busy", 32'(bus0.busy), 0);

    // four held requesters after a fresh reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus0.req_data = 32'h4433_2211;
    bus0.req      = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_load0(40, cyc, acks);
      chk("rr_grant", 32'(bus0.cur_grant),
          32'(exp_g[f]));
      chk("rr_data", 32'(bus0.tx_data),
          32'h11 * (exp_g[f] + 1));
      chk("rr_ackvec", 32'(bus0.req_ack),
          32'(1) << exp_g[f]);
      chk("rr_acks", 32'(acks), 1);
      if (f > 0)
        chk("rr_period", 32'(cyc), 17);
    end

    // abort five cycles into SEND
    wait_load0(40, cyc, acks);
    chk("ab_grant", 32'(bus0.cur_grant),
        32'(exp_ab1));
    repeat (5) step();
    bus0.enable = 1'b0;
    step();
    chk("ab_busy", 32'(bus0.busy), 0);
    chk("ab_tx_en", 32'(bus0.tx_en), 0);
    chk("ab_load", 32'(bus0.tx_load), 0);
    dn = $countones(bus0.req_done);
    repeat (16) begin
      step();
      dn += $countones(bus0.req_done);
    end
    chk("ab_no_done", 32'(dn), 0);
    chk("ab_idle", 32'(bus0.busy), 0);
    bus0.enable = 1'b1;
    wait_load0(40, cyc, acks);
    chk("ab_next", 32'(bus0.cur_grant),
        32'(exp_ab2));

    // zero-gap build, requester 1 held
    bus1.req_data = 32'h0000_5A00;
    bus1.req      = 4'b0010;
    bus1.enable   = 1'b1;
    wait_load1(40, cyc);
    chk("g0_grant", 32'(bus1.cur_grant), 1);
    chk("g0_data", 32'(bus1.tx_data), 32'h5A);
    chk("g0_ack", 32'(bus1.req_ack), 32'b0010);
    wait_load1(40, cyc);
    chk("g0_period1", 32'(cyc), 15);
    wait_load1(40, cyc);
    chk("g0_period2", 32'(cyc), 15);
    bus1.enable = 1'b0;
    bus1.req    = '0;

    // reset asserted in the middle of SEND
    wait_load0(40, cyc, acks);
    repeat (3) step();
    chk("mid_busy_pre", 32'(bus0.busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_busy", 32'(bus0.busy), 0);
    chk("mr_load", 32'(bus0.tx_load), 0);
    chk("mr_tx_en", 32'(bus0.tx_en), 0);
    chk("mr_data", 32'(bus0.tx_data), 0);
    chk("mr_grant", 32'(bus0.cur_grant), 0);
    chk("mr_done", 32'(bus0.req_done), 0);
    @(negedge clk1);
    rst = 1'b1;
    wait_load0(40, cyc, acks);
    chk("mr_first", 32'(bus0.cur_grant), 0);
    chk("mr_fdata", 32'(bus0.tx_data), 32'h11);

    $display("%0d/%0d checks passed",
             n_pass, n_total);
    $finish;
  end

endmodule
